// File: rtl/timer_run_ctrl_if.sv
// Register-port bundle for timer_run_ctrl: write strobe, address, write data
// and the combinational read-back path.
interface timer_run_ctrl_if #(
    parameter int CW = 16
);
    logic          wr_en;
    logic [1:0]    addr;
    logic [CW-1:0] wdata;
    logic [CW-1:0] rd_data;

    modport master (output wr_en, output addr, output wdata, input rd_data);
    modport slave  (input wr_en, input addr, input wdata, output rd_data);
endinterface

// File: rtl/timer_run_ctrl.sv
// Run/stop/reload sequencer and overflow/interrupt tracker for the 16-bit timer.
// Define TIMER_RUN_CTRL_CAPTURE_EN to add the intx input and the CAPTURE register.
module timer_run_ctrl #(
    parameter int CW     = 16,
    parameter int MISS_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    timer_run_ctrl_if.slave     bus,
    input  logic [CW-1:0]       count,
    input  logic                irq_ack,
`ifdef TIMER_RUN_CTRL_CAPTURE_EN
    input  logic                intx,
`endif
    output logic                tr,
    output logic                c_t,
    output logic                gate,
    output logic                load,
    output logic [CW-1:0]       load_val,
    output logic                irq
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RELOAD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       reload_q;
    logic                c_t_q, gate_q, periodic_q, irq_en_q;
    logic                tf_q, irq_q, tr_q, load_q;
    logic [MISS_W-1:0]   miss_q;
    logic [CW-1:0]       capture_rd;
    logic [CW-1:0]       status;
    logic [CW-1:0]       ctrl_rd;

    logic ctrl_wr, start_w, stop_w, start_clr, ovf, cfg_open;

    assign ctrl_wr   = bus.wr_en && (bus.addr == 2'd0);
    assign stop_w    = ctrl_wr && bus.wdata[5];
    assign start_w   = ctrl_wr && bus.wdata[0] && !bus.wdata[5];
    assign start_clr = ctrl_wr && bus.wdata[0];
    assign cfg_open  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign ovf       = (state_q == S_RUN) && (count_q == '1) && (count == '0);

    function automatic logic [1:0] state_code(input state_t s);
        case (s)
            S_IDLE:   state_code = 2'd0;
            S_LOAD:   state_code = 2'd1;
            S_RELOAD: state_code = 2'd1;
            S_RUN:    state_code = 2'd2;
            S_DONE:   state_code = 2'd3;
            default:  state_code = 2'd0;
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start_w) state_d = S_LOAD;
            S_LOAD:   state_d = S_RUN;
            // STOP outranks a coincident wrap; the wrap still flags TF below
            S_RUN: begin
                if (stop_w)   state_d = S_IDLE;
                else if (ovf) state_d = periodic_q ? S_RELOAD : S_DONE;
            end
            S_RELOAD: state_d = S_RUN;
            S_DONE: begin
                if (stop_w)       state_d = S_IDLE;
                else if (start_w) state_d = S_LOAD;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            tr_q    <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tr_q    <= (state_d == S_RUN);
            load_q  <= (state_d == S_LOAD) || (state_d == S_RELOAD);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            reload_q   <= '0;
            c_t_q      <= 1'b0;
            gate_q     <= 1'b0;
            periodic_q <= 1'b0;
            irq_en_q   <= 1'b0;
            tf_q       <= 1'b0;
            miss_q     <= '0;
            irq_q      <= 1'b0;
        end else begin
            count_q <= count;
            if (bus.wr_en && (bus.addr == 2'd1)) reload_q <= bus.wdata;
            if (ctrl_wr) begin
                irq_en_q <= bus.wdata[4];
                if (cfg_open) begin
                    c_t_q      <= bus.wdata[1];
                    gate_q     <= bus.wdata[2];
                    periodic_q <= bus.wdata[3];
                end
            end
            // a wrap coincident with irq_ack keeps TF set
            if (ovf)          tf_q <= 1'b1;
            else if (irq_ack) tf_q <= 1'b0;
            if (start_clr)
                miss_q <= '0;
            else if (ovf && tf_q && (miss_q != '1))
                miss_q <= miss_q + MISS_W'(1);
            irq_q <= tf_q & irq_en_q;
        end
    end

`ifdef TIMER_RUN_CTRL_CAPTURE_EN
    logic          intx_q, intx_prev_q;
    logic [CW-1:0] capture_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            intx_q      <= 1'b0;
            intx_prev_q <= 1'b0;
            capture_q   <= '0;
        end else begin
            intx_q      <= intx;
            intx_prev_q <= intx_q;
            if ((state_q == S_RUN) && intx_q && !intx_prev_q) capture_q <= count;
        end
    end

    assign capture_rd = capture_q;
`else
    assign capture_rd = '0;
`endif

    always_comb begin
        status                 = '0;
        status[0]              = tf_q;
        status[1]              = !cfg_open;
        status[3:2]            = state_code(state_q);
        status[8 +: MISS_W]    = miss_q;
        ctrl_rd                = '0;
        ctrl_rd[1]             = c_t_q;
        ctrl_rd[2]             = gate_q;
        ctrl_rd[3]             = periodic_q;
        ctrl_rd[4]             = irq_en_q;
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.addr)
            2'd0:    bus.rd_data = ctrl_rd;
            2'd1:    bus.rd_data = reload_q;
            2'd2:    bus.rd_data = status;
            2'd3:    bus.rd_data = capture_rd;
            default: bus.rd_data = '0;
        endcase
    end

    assign tr       = tr_q;
    assign load     = load_q;
    assign load_val = reload_q;
    assign c_t      = c_t_q;
    assign gate     = gate_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_timer_run_ctrl.sv
// Scenario bench for timer_run_ctrl: expected load values are queued when a
// load is provoked and popped by a monitor whenever the DUT pulses load.
module tb_timer_run_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] count = 16'h0000;
    logic        irq_ack = 1'b0;
    logic        intx = 1'b0;
    logic        tr, c_t, gate, load, irq;
    logic [15:0] load_val;

    int checks = 0;
    int failures = 0;
    logic [15:0] exp_load_q[$];

    timer_run_ctrl_if #(.CW(16)) bus_if ();

    timer_run_ctrl #(.CW(16), .MISS_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus_if.slave),
        .count    (count),
        .irq_ack  (irq_ack),
`ifdef TIMER_RUN_CTRL_CAPTURE_EN
        .intx     (intx),
`endif
        .tr       (tr),
        .c_t      (c_t),
        .gate     (gate),
        .load     (load),
        .load_val (load_val),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // scoreboard consumer: every load pulse must match the oldest queued value
    always @(negedge clk) begin
        if (load === 1'b1) begin
            checks++;
            if (exp_load_q.size() == 0) begin
                failures++;
                $display("FAIL load_pulse unexpected load, load_val=%h", load_val);
            end else begin
                logic [15:0] e;
                e = exp_load_q.pop_front();
                if (load_val !== e) begin
                    failures++;
                    $display("FAIL load_val got=%h exp=%h", load_val, e);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [15:0] d);
        bus_if.wr_en = 1'b1;
        bus_if.addr  = a;
        bus_if.wdata = d;
        cyc();
        bus_if.wr_en = 1'b0;
        bus_if.wdata = 16'h0000;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] d);
        bus_if.addr = a;
        #1;
        d = bus_if.rd_data;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        checks++;
        if ({tr, c_t, gate, load, irq} !== 5'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00000", {tr, c_t, gate, load, irq});
        end
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0000) begin failures++; $display("FAIL reset_status got=%h exp=0000", v); end
        rd(2'd1, v);
        checks++;
        if (v !== 16'h0000) begin failures++; $display("FAIL reset_reload got=%h exp=0000", v); end
    endtask

    task automatic test_start();
        logic [15:0] v;
        wr(2'd1, 16'hFFF0);
        exp_load_q.push_back(16'hFFF0);
        wr(2'd0, 16'h0001);
        rd(2'd2, v);
        checks++;
        if (load !== 1'b1 || tr !== 1'b0 || v !== 16'h0006) begin
            failures++;
            $display("FAIL start_load load=%b tr=%b status=%h exp load=1 tr=0 status=0006", load, tr, v);
        end
        cyc();
        rd(2'd2, v);
        checks++;
        if (tr !== 1'b1 || load !== 1'b0 || v !== 16'h000A) begin
            failures++;
            $display("FAIL start_run tr=%b load=%b status=%h exp tr=1 load=0 status=000A", tr, load, v);
        end
    endtask

    task automatic test_oneshot();
        logic [15:0] v;
        count = 16'hFFFE; cyc();
        count = 16'hFFFF; cyc();
        count = 16'h0000; cyc();
        rd(2'd2, v);
        checks++;
        if (v !== 16'h000D || tr !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_done status=%h tr=%b exp status=000D tr=0", v, tr);
        end
        cyc();
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL oneshot_irq got=%b exp=0", irq); end
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        rd(2'd2, v);
        checks++;
        if (v !== 16'h000C) begin failures++; $display("FAIL oneshot_ack status=%h exp=000C", v); end
    endtask

    task automatic test_periodic();
        logic [15:0] v;
        exp_load_q.push_back(16'hFFF0);
        wr(2'd0, 16'h0019);
        cyc();
        checks++;
        if (tr !== 1'b1) begin failures++; $display("FAIL periodic_run tr=%b exp=1", tr); end
        count = 16'hFFFF; cyc();
        exp_load_q.push_back(16'hFFF0);
        count = 16'h0000; cyc();
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0007 || tr !== 1'b0 || load !== 1'b1 || irq !== 1'b0) begin
            failures++;
            $display("FAIL periodic_reload status=%h tr=%b load=%b irq=%b exp 0007 0 1 0", v, tr, load, irq);
        end
        cyc();
        checks++;
        if (tr !== 1'b1 || irq !== 1'b1) begin
            failures++;
            $display("FAIL periodic_rerun tr=%b irq=%b exp tr=1 irq=1", tr, irq);
        end
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        cyc();
        rd(2'd2, v);
        checks++;
        if (irq !== 1'b0 || v !== 16'h000A) begin
            failures++;
            $display("FAIL periodic_ack irq=%b status=%h exp irq=0 status=000A", irq, v);
        end
    endtask

    task automatic test_back_to_back_wraps();
        logic [15:0] v;
        exp_load_q.push_back(16'hFFF0);
        count = 16'hFFFF; cyc();
        count = 16'h0000; cyc();
        cyc();
        exp_load_q.push_back(16'hFFF0);
        count = 16'hFFFF; cyc();
        count = 16'h0000; cyc();
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0107) begin failures++; $display("FAIL miss_first status=%h exp=0107", v); end
        cyc();
        exp_load_q.push_back(16'hFFF0);
        count = 16'hFFFF; cyc();
        count = 16'h0000; irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0207) begin failures++; $display("FAIL miss_ack_coincident status=%h exp=0207", v); end
        cyc();
    endtask

    task automatic test_stop_ovf();
        logic [15:0] v;
        irq_ack = 1'b1; cyc(); irq_ack = 1'b0;
        wr(2'd0, 16'h0019);
        rd(2'd2, v);
        checks++;
        if (v !== 16'h000A) begin failures++; $display("FAIL miss_clear status=%h exp=000A", v); end
        count = 16'hFFFF; cyc();
        count = 16'h0000;
        wr(2'd0, 16'h0020);
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0001 || tr !== 1'b0 || load !== 1'b0) begin
            failures++;
            $display("FAIL stop_wins status=%h tr=%b load=%b exp 0001 0 0", v, tr, load);
        end
        cyc();
        wr(2'd0, 16'h0021);
        rd(2'd2, v);
        checks++;
        if (v !== 16'h0001 || load !== 1'b0) begin
            failures++;
            $display("FAIL start_stop_both status=%h load=%b exp 0001 0", v, load);
        end
    endtask

    task automatic test_reset_midrun();
        logic [15:0] v;
        wr(2'd0, 16'h0006);
        checks++;
        if (c_t !== 1'b1 || gate !== 1'b1) begin
            failures++;
            $display("FAIL cfg_latch c_t=%b gate=%b exp 1 1", c_t, gate);
        end
        exp_load_q.push_back(16'hFFF0);
        wr(2'd0, 16'h0007);
        cyc();
        checks++;
        if (tr !== 1'b1 || c_t !== 1'b1) begin
            failures++;
            $display("FAIL cfg_run tr=%b c_t=%b exp 1 1", tr, c_t);
        end
        reset = 1'b1; cyc(); reset = 1'b0;
        rd(2'd2, v);
        checks++;
        if ({tr, c_t, gate, load, irq} !== 5'b0 || v !== 16'h0000) begin
            failures++;
            $display("FAIL reset_midrun outs=%b status=%h exp 00000 0000", {tr, c_t, gate, load, irq}, v);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 16'h0000) begin failures++; $display("FAIL reset_midrun_reload got=%h exp=0000", v); end
        cyc();
    endtask

`ifdef TIMER_RUN_CTRL_CAPTURE_EN
    task automatic test_capture();
        logic [15:0] v;
        exp_load_q.push_back(16'h0000);
        wr(2'd0, 16'h0001);
        cyc();
        count = 16'h0123;
        intx  = 1'b1;
        cyc();
        cyc();
        count = 16'h0200;
        cyc();
        rd(2'd3, v);
        checks++;
        if (v !== 16'h0123) begin failures++; $display("FAIL capture got=%h exp=0123", v); end
        intx = 1'b0;
    endtask
`else
    task automatic test_capture();
        logic [15:0] v;
        rd(2'd3, v);
        checks++;
        if (v !== 16'h0000) begin failures++; $display("FAIL capture_absent got=%h exp=0000", v); end
    endtask
`endif

    initial begin
        bus_if.wr_en = 1'b0;
        bus_if.addr  = 2'd0;
        bus_if.wdata = 16'h0000;
        test_reset();
        test_start();
        test_oneshot();
        test_periodic();
        test_back_to_back_wraps();
        test_stop_ovf();
        test_reset_midrun();
        test_capture();
        cyc();
        checks++;
        if (exp_load_q.size() != 0) begin
            failures++;
            $display("FAIL load_missing pending=%0d exp=0", exp_load_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_run_ctrl.md
Name: timer_run_ctrl

Overview:
- Control/scheduling block for the 16-bit timer/counter datapath (clk, reset, gate, intx, tr, cin, c_t, count).
- Holds the timer configuration registers behind a simple register port. Sequences run, stop and reload of the timer through tr, c_t, gate, load and load_val.
- Detects count overflow by watching count wrap, raises a flag/interrupt with ack handshake, supports one-shot and periodic auto-reload modes.

Parameters:
- CW, 16, timer count width; count, load_val, RELOAD width.
- MISS_W, 8, width of the saturating missed-overflow counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- wr_en  in  1  register write strobe, one write per cycle.
- addr  in  2  register select: 0 CTRL, 1 RELOAD, 2 STATUS, 3 CAPTURE.
- wdata  in  CW  write data.
- rd_data  out  CW  combinational read of register at addr.
- count  in  CW  live timer count.
- irq_ack  in  1  clears TF, single-cycle pulse.
- tr  out  1  timer run enable, registered.
- c_t  out  1  0 = timer (clk), 1 = counter (cin), registered.
- gate  out  1  gate-mode select to timer, registered.
- load  out  1  one-cycle pulse: timer loads load_val.
- load_val  out  CW  value to load, equals RELOAD register.
- irq  out  1  TF & IRQ_EN, registered.

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: all outputs 0, RELOAD=0, TF=0, MISS=0, CAPTURE=0, state IDLE.
- CTRL write bits:
  - [0] START, self-clearing.
  - [1] C_T.
  - [2] GATE.
  - [3] PERIODIC.
  - [4] IRQ_EN.
  - [5] STOP, self-clearing.
  - Bits 1-3 latch only in IDLE or DONE; ignored in LOAD/RUN/RELOAD. IRQ_EN latches in any state.
- RELOAD: writable anytime; used at the next load pulse.
- STATUS read:
  - [0] TF.
  - [1] busy (state != IDLE/DONE).
  - [3:2] state (IDLE=0, LOAD=1, RUN=2, DONE=3; RELOAD reads as 1).
  - [8+MISS_W-1:8] MISS.
  - Other bits 0.
- States:
  - IDLE: tr=0. START -> LOAD.
  - LOAD: load=1 for exactly one cycle, load_val=RELOAD, tr=0. -> RUN next cycle.
  - RUN: tr=1.
    - STOP -> IDLE.
    - ovf & PERIODIC -> RELOAD.
    - ovf & !PERIODIC -> DONE.
  - RELOAD: load=1 one cycle, tr=0. -> RUN.
  - DONE: tr=0. START -> LOAD; STOP -> IDLE.
- Latency: START write at cycle N -> load=1 at N+1 -> tr=1 at N+2. STOP write at cycle N -> tr=0 at N+1.
- Overflow detection: ovf = (count_q == all-ones) && (count == 0) while state==RUN. count_q is count registered every cycle; count_q resets to 0.
- TF:
  - Set on ovf.
  - Cleared by irq_ack.
  - ovf and irq_ack in the same cycle: TF stays 1.
- MISS: +1 on ovf while TF already 1; saturates at all-ones; cleared by CTRL write with START.
- irq = TF & IRQ_EN, one cycle after TF changes.
- Simultaneous STOP and ovf in RUN: STOP wins (-> IDLE, no reload); TF still sets.
- START and STOP both set: STOP wins.
- reset mid-run: next cycle all state per reset values; tr=0, no load pulse.

Optional Feature:
- Macro: TIMER_RUN_CTRL_CAPTURE_EN.
- Defined:
  - Extra input intx (1 bit).
  - Rising edge of intx (registered sample) while RUN copies count into CAPTURE; readable at addr 3.
- Undefined:
  - No intx port, CAPTURE logic absent; addr 3 reads 0.

Test Plan:
- Reset held 2 cycles -> tr=c_t=gate=load=irq=0, STATUS reads 0.
- Write RELOAD=16'hFFF0, CTRL=16'h0001 -> load=1 with load_val=FFF0 next cycle, tr=1 the cycle after.
- One-shot: stub count steps FFFE, FFFF, 0000 -> TF=1, state DONE, tr=0; irq stays 0 with IRQ_EN=0.
- Periodic with IRQ_EN: CTRL=16'h0019, RELOAD=FFF0, count wraps -> TF=1, irq=1, load pulse with FFF0, tr back to 1 after one cycle. irq_ack -> irq=0.
- Second wrap before ack -> MISS=1, TF=1. ack coincident with third wrap -> TF stays 1, MISS=2.
- STOP written in the same cycle count wraps -> state IDLE, no load pulse, TF=1. With CAPTURE_EN: intx rising at count=16'h0123 -> CAPTURE=0123.
